// File: rtl/direction_input_scheduler.sv
// Direction input scheduler for the snake game. Arbitrates the direction buttons,
// rejects duplicate and reversing turns, queues accepted turns and releases one per game tick.
module direction_input_scheduler #(
  parameter int         QUEUE_DEPTH = 2,
  parameter int         CNT_W       = 2,
  parameter logic [1:0] INIT_DIR    = 2'b11
) (
  input  logic             clock_25,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             game_tick,
  input  logic             game_over,
  input  logic             restart,
  output logic [1:0]       direction,
  output logic             moving,
  output logic [CNT_W-1:0] queue_count,
  output logic             drop
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  typedef enum logic [1:0] {S_READY, S_RUN, S_FROZEN} state_t;

  state_t           r_state;
  logic [1:0]       r_fifo [QUEUE_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [1:0]       r_direction;
  logic             r_moving;
  logic             r_drop;

  logic             w_any;
  logic [1:0]       w_req;
  logic [1:0]       w_tail;
  logic [1:0]       w_ref;
  logic             w_full;
  logic             w_pop;
  logic             w_press;
  logic             w_reject;
  logic             w_push;
  logic             w_drop;

  // Fixed priority up > down > left > right; the losers are discarded silently.
  always_comb begin
    w_any = btn_up | btn_down | btn_left | btn_right;
    if (btn_up)         w_req = 2'b00;
    else if (btn_down)  w_req = 2'b01;
    else if (btn_left)  w_req = 2'b10;
    else                w_req = 2'b11;
  end

  assign w_tail   = r_fifo[r_wr_ptr - PTR_W'(1)];
  assign w_ref    = (r_count != '0) ? w_tail : r_direction;
  assign w_full   = (r_count == DEPTH_C);
  assign w_pop    = (r_state == S_RUN) && game_tick && !game_over && !restart && (r_count != '0);
  assign w_press  = w_any && !restart &&
                    ((r_state == S_READY) || ((r_state == S_RUN) && !game_over));
  // A full queue still accepts when the same edge pops the head.
  assign w_reject = (w_req == w_ref) || (w_req == {w_ref[1], ~w_ref[0]}) || (w_full && !w_pop);
  assign w_push   = w_press && !w_reject;
  assign w_drop   = w_press && w_reject;

  always_ff @(posedge clock_25) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_req;
  end

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      r_state     <= S_READY;
      r_direction <= INIT_DIR;
      r_moving    <= 1'b0;
      r_count     <= '0;
      r_drop      <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
    end else if (restart) begin
      r_state     <= S_READY;
      r_direction <= INIT_DIR;
      r_moving    <= 1'b0;
      r_count     <= '0;
      r_drop      <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
    end else begin
      r_drop <= w_drop;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
        r_direction <= r_fifo[r_rd_ptr];
      end
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);

      case (r_state)
        S_READY: begin
          if (w_push) begin
            r_state  <= S_RUN;
            r_moving <= 1'b1;
          end
        end
        S_RUN: begin
          if (game_over) begin
            r_state  <= S_FROZEN;
            r_moving <= 1'b0;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
          end
        end
        S_FROZEN: ;
        default: begin
          r_state  <= S_READY;
          r_moving <= 1'b0;
        end
      endcase
    end
  end

  assign direction   = r_direction;
  assign moving      = r_moving;
  assign queue_count = r_count;
  assign drop        = r_drop;

endmodule

// File: tb/tb_direction_input_scheduler.sv
// Directed bench for direction_input_scheduler: hand-computed direction, count,
// moving and drop after every cycle of stimulus.
module tb_direction_input_scheduler;

  logic       clock_25 = 1'b0;
  logic       reset = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       game_tick = 1'b0, game_over = 1'b0, restart = 1'b0;
  logic [1:0] direction;
  logic       moving;
  logic [1:0] queue_count;
  logic       drop;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [3:0] B_NONE = 4'b0000;
  localparam logic [3:0] B_U    = 4'b1000;
  localparam logic [3:0] B_D    = 4'b0100;
  localparam logic [3:0] B_L    = 4'b0010;
  localparam logic [3:0] B_R    = 4'b0001;

  direction_input_scheduler dut (
    .clock_25   (clock_25),
    .reset      (reset),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .game_tick  (game_tick),
    .game_over  (game_over),
    .restart    (restart),
    .direction  (direction),
    .moving     (moving),
    .queue_count(queue_count),
    .drop       (drop)
  );

  always #20 clock_25 = ~clock_25;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] e_dir, input logic [1:0] e_cnt,
                            input logic e_mov, input logic e_drop);
    chk({tag, "_dir"},  8'(direction),   8'(e_dir));
    chk({tag, "_cnt"},  8'(queue_count), 8'(e_cnt));
    chk({tag, "_mov"},  8'(moving),      8'(e_mov));
    chk({tag, "_drop"}, 8'(drop),        8'(e_drop));
  endtask

  // Drive one cycle of pulses, then sample 1 ns after the active edge.
  task automatic cyc(input logic [3:0] btn, input logic tick, input logic go, input logic rs);
    {btn_up, btn_down, btn_left, btn_right} = btn;
    game_tick = tick;
    game_over = go;
    restart   = rs;
    @(posedge clock_25);
    #1;
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    game_tick = 1'b0;
    game_over = 1'b0;
    restart   = 1'b0;
    $display("t=%0t btn=%b tick=%b go=%b rs=%b -> dir=%0d cnt=%0d mov=%b drop=%b",
             $time, btn, tick, go, rs, direction, queue_count, moving, drop);
  endtask

  initial begin
    repeat (2) @(posedge clock_25);
    #1;
    expect_out("rst", 2'd3, 2'd0, 1'b0, 1'b0);
    #5 reset = 1'b1;

    // T1: reversal rejected in READY, then a valid press starts the game
    cyc(B_L, 0, 0, 0);    expect_out("t1_rev", 2'd3, 2'd0, 1'b0, 1'b1);
    cyc(B_U, 0, 0, 0);    expect_out("t1_up",  2'd3, 2'd1, 1'b1, 1'b0);
    cyc(B_R, 0, 0, 0);    expect_out("s1_r",   2'd3, 2'd2, 1'b1, 1'b0);
    cyc(B_NONE, 1, 0, 0); expect_out("s1_t1",  2'd0, 2'd1, 1'b1, 1'b0);
    cyc(B_NONE, 1, 0, 0); expect_out("s1_t2",  2'd3, 2'd0, 1'b1, 1'b0);

    // T2: two queued turns released one per tick, then an empty tick
    cyc(B_U, 0, 0, 0);    expect_out("t2_u",   2'd3, 2'd1, 1'b1, 1'b0);
    cyc(B_L, 0, 0, 0);    expect_out("t2_l",   2'd3, 2'd2, 1'b1, 1'b0);
    cyc(B_NONE, 1, 0, 0); expect_out("t2_t1",  2'd0, 2'd1, 1'b1, 1'b0);
    cyc(B_NONE, 1, 0, 0); expect_out("t2_t2",  2'd2, 2'd0, 1'b1, 1'b0);
    cyc(B_NONE, 1, 0, 0); expect_out("t2_t3",  2'd2, 2'd0, 1'b1, 1'b0);

    cyc(B_U, 0, 0, 0);    expect_out("s2_u",   2'd2, 2'd1, 1'b1, 1'b0);
    cyc(B_R, 0, 0, 0);    expect_out("s2_r",   2'd2, 2'd2, 1'b1, 1'b0);
    cyc(B_NONE, 1, 0, 0); expect_out("s2_t1",  2'd0, 2'd1, 1'b1, 1'b0);
    cyc(B_NONE, 1, 0, 0); expect_out("s2_t2",  2'd3, 2'd0, 1'b1, 1'b0);

    // T3: full queue rejects; push with simultaneous pop accepted
    cyc(B_U, 0, 0, 0);    expect_out("t3_u",    2'd3, 2'd1, 1'b1, 1'b0);
    cyc(B_L, 0, 0, 0);    expect_out("t3_l",    2'd3, 2'd2, 1'b1, 1'b0);
    cyc(B_D, 0, 0, 0);    expect_out("t3_full", 2'd3, 2'd2, 1'b1, 1'b1);
    cyc(B_D, 1, 0, 0);    expect_out("t3_pp",   2'd0, 2'd2, 1'b1, 1'b0);
    cyc(B_NONE, 1, 0, 0); expect_out("t3_t1",   2'd2, 2'd1, 1'b1, 1'b0);
    cyc(B_NONE, 1, 0, 0); expect_out("t3_t2",   2'd1, 2'd0, 1'b1, 1'b0);

    // Tick + press on an empty queue: enqueued, applied on the next tick
    cyc(B_L, 1, 0, 0);    expect_out("te_pt",   2'd1, 2'd1, 1'b1, 1'b0);
    cyc(B_NONE, 1, 0, 0); expect_out("te_t",    2'd2, 2'd0, 1'b1, 1'b0);

    // T4: simultaneous presses arbitrated, duplicate of tail dropped
    cyc(B_U | B_R, 0, 0, 0); expect_out("t4_arb", 2'd2, 2'd1, 1'b1, 1'b0);
    cyc(B_U, 0, 0, 0);       expect_out("t4_dup", 2'd2, 2'd1, 1'b1, 1'b1);

    // T5: game_over with tick freezes and flushes; FROZEN ignores inputs; restart
    cyc(B_L, 0, 0, 0);       expect_out("t5_l",   2'd2, 2'd2, 1'b1, 1'b0);
    cyc(B_NONE, 1, 1, 0);    expect_out("t5_go",  2'd2, 2'd0, 1'b0, 1'b0);
    cyc(B_D, 1, 1, 0);       expect_out("t5_frz", 2'd2, 2'd0, 1'b0, 1'b0);
    cyc(B_NONE, 1, 0, 0);    expect_out("t5_frt", 2'd2, 2'd0, 1'b0, 1'b0);
    cyc(B_U, 0, 0, 1);       expect_out("t5_rs",  2'd3, 2'd0, 1'b0, 1'b0);
    cyc(B_U, 0, 0, 0);       expect_out("t5_rdy", 2'd3, 2'd1, 1'b1, 1'b0);

    // T6: asynchronous reset mid-RUN with a full queue and drop pending
    cyc(B_L, 0, 0, 0);    expect_out("t6_l",   2'd3, 2'd2, 1'b1, 1'b0);
    cyc(B_NONE, 1, 0, 0); expect_out("t6_t",   2'd0, 2'd1, 1'b1, 1'b0);
    cyc(B_D, 0, 0, 0);    expect_out("t6_d",   2'd0, 2'd2, 1'b1, 1'b0);
    cyc(B_R, 0, 0, 0);    expect_out("t6_r",   2'd0, 2'd2, 1'b1, 1'b1);
    #10 reset = 1'b0;
    #1  expect_out("t6_arst", 2'd3, 2'd0, 1'b0, 1'b0);
    @(posedge clock_25);
    #1  expect_out("t6_hold", 2'd3, 2'd0, 1'b0, 1'b0);
    #5 reset = 1'b1;
    cyc(B_L, 0, 0, 0);    expect_out("t6_rev", 2'd3, 2'd0, 1'b0, 1'b1);
    cyc(B_D, 0, 0, 0);    expect_out("t6_go",  2'd3, 2'd1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
